// File: rtl/sdram_auto_refresh_pkg.sv
// Shared SDRAM command encodings and default timing.
// Used by the init, arbiter and auto-refresh stages.
package sdram_auto_refresh_pkg;

    localparam logic [3:0]  NOP       = 4'b0111;
    localparam logic [3:0]  P_CHARGE  = 4'b0010;
    localparam logic [3:0]  AUTO_REF  = 4'b0001;
    localparam logic [3:0]  M_REG_SET = 4'b0000;

    localparam int TRP_CLK  = 2;
    localparam int TRC_CLK  = 7;
    localparam int TMRD_CLK = 3;
    localparam int CNT_REF  = 750;

    localparam logic [1:0]  BA_ALL   = 2'b11;
    localparam logic [12:0] ADDR_ALL = 13'h1fff;

endpackage

// File: rtl/sdram_auto_refresh.sv
// Periodic auto-refresh generator: request, precharge-all,
// then a burst of AUTO REFRESH commands with tRP/tRC spacing.
module sdram_auto_refresh
    import sdram_auto_refresh_pkg::*;
#(
    parameter int CNT_REF  = sdram_auto_refresh_pkg::CNT_REF,
    parameter int TRP_CLK  = sdram_auto_refresh_pkg::TRP_CLK,
    parameter int TRC_CLK  = sdram_auto_refresh_pkg::TRC_CLK,
    parameter int AREF_NUM = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_ba,
    output logic [12:0] aref_addr,
    output logic        aref_end
);

    localparam int CW       = $clog2(CNT_REF);
    localparam int WAIT_MAX = (TRC_CLK > TRP_CLK) ? TRC_CLK : TRP_CLK;
    localparam int WW       = $clog2(WAIT_MAX + 1);
    localparam int RW       = $clog2(AREF_NUM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PCHA,
        S_TRP,
        S_AREF,
        S_TRF,
        S_END
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wait_cnt;
    logic [RW-1:0]   ref_cnt;
    logic            cnt_last;

    assign cnt_last = (cnt == CW'(CNT_REF - 1));

    // Free-running refresh interval and the pending request flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !init_end) begin
            cnt      <= '0;
            aref_req <= 1'b0;
        end else begin
            cnt <= cnt_last ? '0 : cnt + CW'(1);
            if (cnt_last)
                aref_req <= 1'b1;
            else if (state == S_IDLE && aref_en)
                aref_req <= 1'b0;
        end
    end

    // Burst sequencer; commands are a registered decode of the current state
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            ref_cnt   <= '0;
            aref_cmd  <= NOP;
            aref_ba   <= BA_ALL;
            aref_addr <= ADDR_ALL;
        end else begin
            aref_ba   <= BA_ALL;
            aref_addr <= ADDR_ALL;
            unique case (state)
                S_PCHA:  aref_cmd <= P_CHARGE;
                S_AREF:  aref_cmd <= AUTO_REF;
                default: aref_cmd <= NOP;
            endcase
            unique case (state)
                S_IDLE: begin
                    if (aref_req && aref_en)
                        state <= S_PCHA;
                end
                S_PCHA: begin
                    state <= S_TRP;
                end
                S_TRP: begin
                    if (wait_cnt == WW'(TRP_CLK - 1)) begin
                        wait_cnt <= '0;
                        state    <= S_AREF;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_AREF: begin
                    ref_cnt <= ref_cnt + RW'(1);
                    state   <= S_TRF;
                end
                S_TRF: begin
                    if (wait_cnt == WW'(TRC_CLK - 1)) begin
                        wait_cnt <= '0;
                        if (ref_cnt == RW'(AREF_NUM))
                            state <= S_END;
                        else
                            state <= S_AREF;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_END: begin
                    ref_cnt <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign aref_end = (state == S_END);

endmodule
